dht_cmd_scheduler: RTL

DHT_CMD_SCHEDULER -- requirements
Module: dht_cmd_scheduler

---
 rtl/dht_sched_pkg.sv | 36 +++
 rtl/cont_tick_timer.sv | 23 ++
 rtl/dht_cmd_scheduler.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/dht_sched_pkg.sv
// rtl/dht_sched_pkg.sv - command/response codes, FSM states and checksum helper for dht_cmd_scheduler
package dht_sched_pkg;

  localparam logic [7:0] CMD_STATUS    = 8'h00;
  localparam logic [7:0] CMD_TEMP      = 8'h01;
  localparam logic [7:0] CMD_HUM       = 8'h02;
  localparam logic [7:0] CMD_CONT_TEMP = 8'h03;
  localparam logic [7:0] CMD_CONT_HUM  = 8'h04;
  localparam logic [7:0] CMD_CONT_OFF  = 8'h05;

  localparam logic [7:0] RESP_STATUS   = 8'h07;
  localparam logic [7:0] RESP_HUM      = 8'h08;
  localparam logic [7:0] RESP_TEMP     = 8'h09;
  localparam logic [7:0] RESP_CONT_OFF = 8'h0A;
  localparam logic [7:0] RESP_FAIL     = 8'h1F;
  localparam logic [7:0] RESP_BAD_ADDR = 8'hFE;
  localparam logic [7:0] RESP_BAD_CMD  = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_START,
    ST_WAIT_SENS,
    ST_FORMAT,
    ST_TX_WAIT,
    ST_TX_FIRE
  } state_t;

  // DHT11 frame: checksum byte is the 8-bit sum of the four data bytes
  function automatic logic checksum_ok(input logic [39:0] d);
    logic [7:0] s;
    s = d[39:32] + d[31:24] + d[23:16] + d[15:8];
    return s == d[7:0];
  endfunction

endpackage

// File: rtl/cont_tick_timer.sv
// rtl/cont_tick_timer.sv - period counter producing the continuous-mode read tick
module cont_tick_timer #(
  parameter int unsigned PERIOD = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int W = $clog2(PERIOD);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                cnt <= '0;
    else if (clear || tick) cnt <= '0;
    else                    cnt <= cnt + W'(1);
  end

  assign tick = !clear && (cnt == W'(PERIOD - 1));

endmodule

// File: rtl/dht_cmd_scheduler.sv
// rtl/dht_cmd_scheduler.sv - host command scheduler for a bank of DHT11 controllers
// Optional macro DHT_CHECKSUM_CHECK_EN: sensor frames with a bad checksum count as failed reads.
module dht_cmd_scheduler
  import dht_sched_pkg::*;
#(
  parameter int unsigned N_SENS      = 8,
  parameter int unsigned TIMEOUT_CYC = 2_500_000,
  parameter int unsigned CONT_PERIOD = 100_000_000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [15:0]               rx_data,
  input  logic                      rx_valid,
  output logic [$clog2(N_SENS)-1:0] sens_sel,
  output logic                      sens_start,
  input  logic                      sens_done,
  input  logic                      sens_err,
  input  logic [39:0]               sens_data,
  output logic [15:0]               tx_data,
  output logic                      tx_start,
  input  logic                      tx_busy,
  output logic                      cmd_drop
);

  localparam int SW = $clog2(N_SENS);
  localparam int TW = $clog2(TIMEOUT_CYC);

  state_t        state, next_state;
  logic          pend_valid, pend_take;
  logic [15:0]   pend_data, cur_rx;
  logic [7:0]    cur_cmd, cur_cmd_nxt;
  logic [SW-1:0] sel_nxt, cont_sel;
  logic [TW-1:0] tout_cnt;
  logic [15:0]   resp_q, resp_nxt;
  logic          resp_load;
  logic          cont_en, cont_hum, cont_set, cont_clr;
  logic          tick, tick_pend, tick_take, tick_clr;
  logic          addr_ok, timeout, sum_ok;

`ifdef DHT_CHECKSUM_CHECK_EN
  assign sum_ok = checksum_ok(sens_data);
`else
  logic unused_sens;
  assign sum_ok      = 1'b1;
  assign unused_sens = ^{sens_data[31:24], sens_data[15:0]};
`endif

  assign addr_ok  = 32'(cur_rx[7:0]) < N_SENS;
  assign timeout  = tout_cnt == TW'(TIMEOUT_CYC - 1);
  assign tick_clr = !cont_en || cont_set;

  cont_tick_timer #(.PERIOD(CONT_PERIOD)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (tick_clr),
    .tick  (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state  = state;
    pend_take   = 1'b0;
    tick_take   = 1'b0;
    sel_nxt     = sens_sel;
    cur_cmd_nxt = cur_cmd;
    resp_load   = 1'b0;
    resp_nxt    = resp_q;
    cont_set    = 1'b0;
    cont_clr    = 1'b0;
    case (state)
      ST_IDLE: begin
        // host commands take priority over a waiting continuous tick
        if (pend_valid) begin
          pend_take  = 1'b1;
          next_state = ST_DECODE;
        end else if (tick_pend) begin
          tick_take   = 1'b1;
          sel_nxt     = cont_sel;
          cur_cmd_nxt = cont_hum ? CMD_HUM : CMD_TEMP;
          next_state  = ST_START;
        end
      end
      ST_DECODE: begin
        if (cur_rx[15:8] > CMD_CONT_OFF) begin
          resp_load  = 1'b1;
          resp_nxt   = {RESP_BAD_CMD, 8'h00};
          next_state = ST_FORMAT;
        end else if (!addr_ok) begin
          resp_load  = 1'b1;
          resp_nxt   = {RESP_BAD_ADDR, cur_rx[7:0]};
          next_state = ST_FORMAT;
        end else if (cur_rx[15:8] == CMD_CONT_OFF) begin
          cont_clr   = 1'b1;
          resp_load  = 1'b1;
          resp_nxt   = {RESP_CONT_OFF, 8'h00};
          next_state = ST_FORMAT;
        end else begin
          sel_nxt    = cur_rx[SW-1:0];
          next_state = ST_START;
          if (cur_rx[15:8] == CMD_CONT_TEMP) begin
            cont_set    = 1'b1;
            cur_cmd_nxt = CMD_TEMP;
          end else if (cur_rx[15:8] == CMD_CONT_HUM) begin
            cont_set    = 1'b1;
            cur_cmd_nxt = CMD_HUM;
          end else begin
            cur_cmd_nxt = cur_rx[15:8];
          end
        end
      end
      ST_START: next_state = ST_WAIT_SENS;
      ST_WAIT_SENS: begin
        if (sens_done || sens_err || timeout) begin
          resp_load  = 1'b1;
          next_state = ST_FORMAT;
          if (sens_done && !sens_err && sum_ok) begin
            case (cur_cmd)
              CMD_TEMP: resp_nxt = {RESP_TEMP, sens_data[23:16]};
              CMD_HUM:  resp_nxt = {RESP_HUM, sens_data[39:32]};
              default:  resp_nxt = {RESP_STATUS, 8'h00};
            endcase
          end else begin
            resp_nxt = {RESP_FAIL, 8'h00};
          end
        end
      end
      ST_FORMAT:  next_state = ST_TX_WAIT;
      ST_TX_WAIT: if (!tx_busy) next_state = ST_TX_FIRE;
      ST_TX_FIRE: next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_valid <= 1'b0;
      pend_data  <= '0;
      cur_rx     <= '0;
      cur_cmd    <= '0;
      sens_sel   <= '0;
      sens_start <= 1'b0;
      tout_cnt   <= '0;
      resp_q     <= '0;
      tx_data    <= '0;
      tx_start   <= 1'b0;
      cmd_drop   <= 1'b0;
      cont_en    <= 1'b0;
      cont_hum   <= 1'b0;
      cont_sel   <= '0;
      tick_pend  <= 1'b0;
    end else begin
      // a slot freed by this cycle's drain can take the arriving command
      if (rx_valid && (!pend_valid || pend_take)) begin
        pend_valid <= 1'b1;
        pend_data  <= rx_data;
      end else if (pend_take) begin
        pend_valid <= 1'b0;
      end
      cmd_drop <= rx_valid && pend_valid && !pend_take;
      if (pend_take) cur_rx <= pend_data;

      if (next_state == ST_START) begin
        sens_sel <= sel_nxt;
        cur_cmd  <= cur_cmd_nxt;
      end
      sens_start <= next_state == ST_START;
      tx_start   <= next_state == ST_TX_FIRE;

      if (state == ST_START)          tout_cnt <= '0;
      else if (state == ST_WAIT_SENS) tout_cnt <= tout_cnt + TW'(1);

      if (resp_load)          resp_q  <= resp_nxt;
      if (state == ST_FORMAT) tx_data <= resp_q;

      if (cont_set) begin
        cont_en  <= 1'b1;
        cont_hum <= cur_rx[15:8] == CMD_CONT_HUM;
        cont_sel <= cur_rx[SW-1:0];
      end else if (cont_clr) begin
        cont_en <= 1'b0;
      end

      // at most one tick is remembered while the scheduler is busy
      if (cont_set || cont_clr) tick_pend <= 1'b0;
      else if (tick)            tick_pend <= 1'b1;
      else if (tick_take)       tick_pend <= 1'b0;
    end
  end

endmodule
